// File: rtl/digit_row_scanner.sv
// digit_row_scanner: snapshots NUM_DIGITS 7-segment codes, walks each line of
// every digit through the external segments_to_bitmap converter and streams
// the returned rows as a valid/ready pixel stream with blank inter-digit gaps.
module digit_row_scanner #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned LINES      = 5,
    parameter int unsigned GAP        = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7*NUM_DIGITS-1:0] segs_in,
    output logic [6:0]              segments,
    output logic [2:0]              line,
    input  logic [4:0]              bits,
    output logic                    pix,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    pix_eol,
    output logic                    pix_eof,
    output logic                    busy
);

    localparam int unsigned SEG_W = 7 * NUM_DIGITS;
    localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
    localparam logic [2:0]       LAST_LINE  = 3'(LINES - 1);
    localparam logic [2:0]       GAP_LAST   = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state;
    logic [SEG_W-1:0] snap;
    logic [DIG_W-1:0] digit;
    logic [DIG_W-1:0] digit_nxt;
    logic [4:0]       shreg;
    logic [2:0]       col;
    logic [2:0]       gcnt;
    logic             last_digit;
    logic             last_line;

    // Segment code of digit d within the frame snapshot.
    function automatic logic [6:0] seg_of(input logic [SEG_W-1:0] s,
                                          input logic [DIG_W-1:0] d);
        return s[7*int'(d) +: 7];
    endfunction

    // Position flags for the digit/line walk.
    always_comb begin
        last_digit = (digit == LAST_DIGIT);
        last_line  = (line == LAST_LINE);
        digit_nxt  = DIG_W'(digit + 1'b1);
    end

    // Scanner FSM with registered converter and pixel-stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            snap      <= '0;
            digit     <= '0;
            line      <= 3'd0;
            segments  <= 7'd0;
            shreg     <= 5'd0;
            col       <= 3'd0;
            gcnt      <= 3'd0;
            pix       <= 1'b0;
            pix_valid <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        snap     <= segs_in;
                        digit    <= '0;
                        line     <= 3'd0;
                        segments <= segs_in[6:0];
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    // converter inputs were registered last edge, so bits is settled
                    shreg     <= bits;
                    pix       <= bits[4];
                    pix_valid <= 1'b1;
                    pix_eol   <= 1'b0;
                    pix_eof   <= 1'b0;
                    col       <= 3'd0;
                    state     <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (pix_ready) begin
                        if (col == 3'd4) begin
                            pix     <= 1'b0;
                            pix_eol <= 1'b0;
                            pix_eof <= 1'b0;
                            if (!last_digit) begin
                                if (GAP > 0) begin
                                    gcnt  <= 3'd0;
                                    state <= ST_GAP;
                                end else begin
                                    digit     <= digit_nxt;
                                    segments  <= seg_of(snap, digit_nxt);
                                    pix_valid <= 1'b0;
                                    state     <= ST_LOAD;
                                end
                            end else if (!last_line) begin
                                line      <= line + 3'd1;
                                digit     <= '0;
                                segments  <= snap[6:0];
                                pix_valid <= 1'b0;
                                state     <= ST_LOAD;
                            end else begin
                                pix_valid <= 1'b0;
                                busy      <= 1'b0;
                                state     <= ST_IDLE;
                            end
                        end else begin
                            col     <= col + 3'd1;
                            shreg   <= {shreg[3:0], 1'b0};
                            pix     <= shreg[3];
                            pix_eol <= last_digit && (col == 3'd3);
                            pix_eof <= last_digit && last_line && (col == 3'd3);
                        end
                    end
                end

                ST_GAP: begin
                    if (pix_ready) begin
                        if (gcnt == GAP_LAST) begin
                            digit     <= digit_nxt;
                            segments  <= seg_of(snap, digit_nxt);
                            pix_valid <= 1'b0;
                            state     <= ST_LOAD;
                        end else begin
                            gcnt <= gcnt + 3'd1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/digit_row_scanner.md
Name: digit_row_scanner

Overview:
- Sequential front end for the existing segments_to_bitmap converter.
- Snapshots NUM_DIGITS 7-segment codes, then walks lines 0..LINES-1 and, per line, digits left to right.
- For each (digit, line) it presents segments/line to the converter and captures the 5-bit row it returns.
- Serialises the rows as a pixel stream with valid/ready handshake, inserting GAP blank columns between digits, for the downstream display/framebuffer writer.

Parameters:
- NUM_DIGITS, 4: digits per row; digit 0 is leftmost, in segs_in[6:0]; digit k in segs_in[7k+6:7k].
- LINES, 5: lines scanned per frame, 1..8; line index is 3 bits.
- GAP, 1: blank (0) pixels between adjacent digits, 0..7; none after the last digit.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  frame request pulse, honoured only when busy=0
- segs_in  in  7*NUM_DIGITS  segment codes, bit6..bit0 per digit, sampled on accepted start
- segments  out  7  segment code of current digit, to converter
- line  out  3  current line index, to converter
- bits  in  5  converter row, bit4 = leftmost pixel
- pix  out  1  pixel value
- pix_valid  out  1  pixel available
- pix_ready  in  1  consumer accepts pixel
- pix_eol  out  1  qualifies pix_valid: last pixel of a line
- pix_eof  out  1  qualifies pix_valid: last pixel of the frame
- busy  out  1  frame in progress

Behaviour:
- Reset, synchronous on rst=1 at a clk edge: state IDLE.
  - busy, pix, pix_valid, pix_eol, pix_eof = 0; segments = 0; line = 0.
  - Counters and snapshot cleared.
  - rst mid-frame aborts immediately; a partially sent line is not completed.
  - rst has priority over start.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - start=1 latches segs_in into a snapshot, sets digit=0, line=0, drives segments=snapshot[0], busy=1, moves to LOAD.
  - Later changes to segs_in do not affect the frame.
  - start while busy=1 is ignored.
- LOAD (exactly 1 cycle):
  - segments/line are already stable (registered).
  - bits is sampled into a 5-bit shift register at the end of the cycle; column count = 0.
  - Next state SHIFT; pix_valid = 0 in LOAD.
- SHIFT:
  - pix_valid=1, pix = shift register MSB.
  - On pix_valid & pix_ready: shift left, column+1.
  - Pixel outputs hold stable while pix_ready=0.
  - After the 5th accepted pixel:
    - not last digit, GAP>0: go to GAP;
    - not last digit, GAP=0: digit+1, go to LOAD;
    - last digit, not last line: line+1, digit=0, go to LOAD;
    - last digit, last line: go to IDLE, busy=0 the cycle after the final handshake.
  - segments/line update in the same edge that enters LOAD.
- GAP:
  - pix_valid=1, pix=0, for GAP accepted pixels.
  - Then digit+1, LOAD.
- pix_eol=1 only while the 5th pixel of the last digit is presented; pix_eof=1 additionally on the last line. Both are 0 whenever pix_valid=0.
- Pixels per line = 5*NUM_DIGITS + GAP*(NUM_DIGITS-1); default 23/line, 115/frame.
- Throughput with pix_ready held 1: one pixel per cycle, plus one LOAD bubble per digit.
  - Default frame: start edge to final handshake = 115 + 20 = 135 cycles.
- A start presented on the same cycle busy falls is ignored (busy still 1); it is accepted one cycle later.

Test Plan:
- rst held 3 cycles mid-frame, then released -> all outputs 0, state IDLE, no pixel with pix_valid=1 until a new start.
- All digits 7'b1111111 ("8"), pix_ready=1 -> line0 stream 01110 0 01110 0 01110 0 01110.
  - Line1 stream is 10001 repeated with 0 gaps.
  - 115 pixels total, pix_eol on pixels 23/46/69/92/115, pix_eof on pixel 115 only, busy low 135 cycles after start.
- Digits 0..3 = 7'b0110000 ("1") -> every line 00001 0 00001 0 00001 0 00001; segments output equals 7'b0110000 during every LOAD.
- Random pix_ready backpressure (~50%) with mixed digits -> captured stream identical to the pix_ready=1 run; pix/pix_eol/pix_eof never change while pix_valid=1 and pix_ready=0.
- Change segs_in and pulse start during a frame -> frame output unaffected; start ignored; busy falls once; a new start afterwards uses the new segs_in.
- NUM_DIGITS=1, GAP=0, LINES=1 -> exactly 5 pixels, last has pix_eol=pix_eof=1.
  - NUM_DIGITS=2, GAP=0 -> 10 pixels/line with no blank column.
